// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if -- bundle of the FIFO read side and the packed output
// stream of fifo_rd_packer.
//
// Signals:
//   rdata    FIFO head word, meaningful only while rempty=0
//   rempty   FIFO empty flag, already in the rclk domain
//   rinc     pop strobe; the head word is consumed on the rclk edge where rinc=1
//   flush    request to push out a partially filled beat
//   m_data   packed beat, lane 0 (bits [DSIZE-1:0]) holds the oldest word
//   m_keep   per-lane valid mask for m_data
//   m_valid  beat available
//   m_ready  downstream accepts the beat
//   beat_cnt count of accepted beats (wraps at 16 bits)
//
// Handshake: a beat transfers on every rclk edge where m_valid=1 and m_ready=1.
// Once m_valid is raised, m_data/m_keep are held stable and m_valid stays high
// until that transfer; m_valid never depends combinationally on m_ready, and a
// new beat may be loaded in the same cycle the previous one transfers.
//
// Modports: master = the packer (drives rinc and the stream), slave = the
// FIFO/consumer side.
interface fifo_rd_packer_if #(
  parameter int DSIZE = 8,
  parameter int RATIO = 2
) ();
  logic [DSIZE-1:0]       rdata;
  logic                   rempty;
  logic                   rinc;
  logic                   flush;
  logic [DSIZE*RATIO-1:0] m_data;
  logic [RATIO-1:0]       m_keep;
  logic                   m_valid;
  logic                   m_ready;
  logic [15:0]            beat_cnt;

  modport master (
    input  rdata, rempty, flush, m_ready,
    output rinc, m_data, m_keep, m_valid, beat_cnt
  );

  modport slave (
    output rdata, rempty, flush, m_ready,
    input  rinc, m_data, m_keep, m_valid, beat_cnt
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer -- read-clock-domain stage behind an async FIFO. Pops FIFO
// words and packs RATIO of them into one wide beat on a valid/ready stream.
// A flush request pushes out a partially filled beat with unfilled lanes zero
// and masked off in m_keep.
//
// Ports:
//   rclk             read clock
//   rrst             asynchronous active-high reset
//   bus              fifo_rd_packer_if.master (FIFO read side + output stream)
//   dbg_idx_o        current lane index (number of staged words), zero-extended
//   dbg_flush_pend_o sticky flush request waiting to be serviced
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 2
) (
  input  logic              rclk,
  input  logic              rrst,
  fifo_rd_packer_if.master  bus,
  output logic [7:0]        dbg_idx_o,
  output logic              dbg_flush_pend_o
);
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int W  = DSIZE * RATIO;
  localparam logic [IW-1:0] LAST = IW'(RATIO - 1);

  logic [IW-1:0]                 idx_q, idx_d;
  logic [RATIO-2:0][DSIZE-1:0]   stage_q, stage_d;
  logic [W-1:0]                  m_data_q, m_data_d;
  logic [RATIO-1:0]              m_keep_q, m_keep_d;
  logic                          m_valid_q, m_valid_d;
  logic                          flush_pend_q, flush_pend_d;
  logic [15:0]                   beat_cnt_q, beat_cnt_d;

  logic                          out_free;
  logic                          pop;
  logic                          accept;
  logic                          load_full;
  logic                          load_part;
  logic [W-1:0]                  part_data;
  logic [RATIO-1:0]              part_keep;

  // The output register can take a new beat when empty or when its current
  // beat transfers this cycle.
  assign out_free  = !m_valid_q || bus.m_ready;
  // The completing pop is only allowed when the output register can take the
  // beat; pops for the lower lanes only need staging space.
  assign pop       = !rrst && !bus.rempty && !bus.flush && !flush_pend_q &&
                     ((idx_q != LAST) || out_free);
  assign accept    = m_valid_q && bus.m_ready;
  assign load_full = pop && (idx_q == LAST);
  // pop is blocked while flush_pend_q is set, so load_full and load_part
  // never coincide.
  assign load_part = flush_pend_q && (idx_q != '0) && out_free;

  // Partial beat: only lanes below idx are filled; stale staging contents in
  // higher lanes are masked to zero. The top lane is never filled here.
  always_comb begin
    part_data = '0;
    part_keep = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (i < int'(idx_q)) begin
        part_data[i*DSIZE +: DSIZE] = stage_q[i];
        part_keep[i]                = 1'b1;
      end
    end
  end

  always_comb begin
    idx_d        = idx_q;
    stage_d      = stage_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q;
    flush_pend_d = flush_pend_q;
    beat_cnt_d   = beat_cnt_q;

    for (int i = 0; i < RATIO - 1; i++) begin
      if (pop && (idx_q == IW'(i))) begin
        stage_d[i] = bus.rdata;
      end
    end

    if (pop) begin
      idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
    end

    if (accept) begin
      m_valid_d  = 1'b0;
      beat_cnt_d = beat_cnt_q + 16'd1;
    end

    // Loading overrides the clear above, giving back-to-back beats.
    if (load_full) begin
      m_data_d  = {bus.rdata, stage_q};
      m_keep_d  = '1;
      m_valid_d = 1'b1;
    end else if (load_part) begin
      m_data_d  = part_data;
      m_keep_d  = part_keep;
      m_valid_d = 1'b1;
      idx_d     = '0;
    end

    // Service: nothing staged -> just drop the request; otherwise wait until
    // the partial beat has been loaded.
    if (flush_pend_q && ((idx_q == '0) || out_free)) begin
      flush_pend_d = 1'b0;
    end
    if (bus.flush) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      idx_q        <= '0;
      stage_q      <= '0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_valid_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
      flush_pend_q <= flush_pend_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus.rinc     = pop;
  assign bus.m_data   = m_data_q;
  assign bus.m_keep   = m_keep_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.beat_cnt = beat_cnt_q;

  assign dbg_idx_o        = 8'(idx_q);
  assign dbg_flush_pend_o = flush_pend_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer -- self-checking bench for fifo_rd_packer (DSIZE=8,
// RATIO=2): reset checks, a table of per-cycle vectors, hand-written reset
// and counter-wrap sequences, then randomized traffic against a queue model.
module tb_fifo_rd_packer;
  localparam int DSIZE = 8;
  localparam int RATIO = 2;

  // ---------------- clock / reset ----------------
  logic rclk = 1'b0;
  logic rrst = 1'b1;
  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) bus ();
  logic [7:0] dbg_idx;
  logic       dbg_fp;

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk             (rclk),
    .rrst             (rrst),
    .bus              (bus),
    .dbg_idx_o        (dbg_idx),
    .dbg_flush_pend_o (dbg_fp)
  );

  typedef struct {
    logic        rempty;
    logic [7:0]  rdata;
    logic        flush;
    logic        m_ready;
    logic        e_rinc;
    logic        e_valid;
    logic [15:0] e_data;
    logic [1:0]  e_keep;
    logic [7:0]  e_idx;
    logic        e_fp;
    logic [15:0] e_cnt;
  } vec_t;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // ---------------- scoreboard / model state ----------------
  logic [17:0] exp_q[$];   // {keep, data} of the beat held in the output register
  logic [7:0]  stg_q[$];   // words popped but not yet emitted
  logic [7:0]  fifo_q[$];  // contents of the upstream FIFO
  logic        m_fp;
  logic [15:0] m_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached (got timeout, required finish)");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rempty, input logic [7:0] rdata,
                       input logic flush, input logic m_ready);
    bus.rempty  = rempty;
    bus.rdata   = rdata;
    bus.flush   = flush;
    bus.m_ready = m_ready;
  endtask

  // Called at a negedge: drives inputs, checks the cycle, advances one cycle.
  task automatic apply_row(input vec_t v, input string tag);
    drive(v.rempty, v.rdata, v.flush, v.m_ready);
    #1;
    check({tag, ".rinc"},    32'(bus.rinc),     32'(v.e_rinc));
    check({tag, ".m_valid"}, 32'(bus.m_valid),  32'(v.e_valid));
    if (v.e_valid) begin
      check({tag, ".m_data"}, 32'(bus.m_data), 32'(v.e_data));
      check({tag, ".m_keep"}, 32'(bus.m_keep), 32'(v.e_keep));
    end
    check({tag, ".idx"},      32'(dbg_idx),      32'(v.e_idx));
    check({tag, ".flush_pend"}, 32'(dbg_fp),     32'(v.e_fp));
    check({tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(v.e_cnt));
    @(posedge rclk);
    @(negedge rclk);
  endtask

  function automatic vec_t row(input logic re, input logic [7:0] rd, input logic fl,
                               input logic rdy, input logic ri, input logic mv,
                               input logic [15:0] md, input logic [1:0] mk,
                               input logic [7:0] ix, input logic fp, input logic [15:0] cn);
    vec_t v;
    v.rempty = re; v.rdata = rd; v.flush = fl; v.m_ready = rdy;
    v.e_rinc = ri; v.e_valid = mv; v.e_data = md; v.e_keep = mk;
    v.e_idx = ix; v.e_fp = fp; v.e_cnt = cn;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, ".m_valid"},  32'(bus.m_valid),  32'd0);
    check({tag, ".m_data"},   32'(bus.m_data),   32'd0);
    check({tag, ".m_keep"},   32'(bus.m_keep),   32'd0);
    check({tag, ".beat_cnt"}, 32'(bus.beat_cnt), 32'd0);
    check({tag, ".rinc"},     32'(bus.rinc),     32'd0);
    check({tag, ".idx"},      32'(dbg_idx),      32'd0);
    check({tag, ".flush_pend"}, 32'(dbg_fp),     32'd0);
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[$];

  initial begin
    // Reset state with a non-empty FIFO: rinc must stay low.
    drive(1'b0, 8'h5A, 1'b0, 1'b1);
    #1;
    check_reset_state("reset");
    @(negedge rclk);
    @(negedge rclk);
    rrst = 1'b0;

    // Two words, ready high, then back-pressure, flush and flush-wait cases.
    tbl.push_back(row(0, 8'h11, 0, 1,  1, 0, 16'h0000, 2'd0, 0, 0, 16'd0));
    tbl.push_back(row(0, 8'h22, 0, 1,  1, 0, 16'h0000, 2'd0, 1, 0, 16'd0));
    tbl.push_back(row(1, 8'h00, 0, 1,  0, 1, 16'h2211, 2'd3, 0, 0, 16'd0));
    tbl.push_back(row(1, 8'h00, 0, 0,  0, 0, 16'h0000, 2'd0, 0, 0, 16'd1));
    tbl.push_back(row(0, 8'h11, 0, 0,  1, 0, 16'h0000, 2'd0, 0, 0, 16'd1));
    tbl.push_back(row(0, 8'h22, 0, 0,  1, 0, 16'h0000, 2'd0, 1, 0, 16'd1));
    tbl.push_back(row(0, 8'h33, 0, 0,  1, 1, 16'h2211, 2'd3, 0, 0, 16'd1));
    tbl.push_back(row(0, 8'h44, 0, 0,  0, 1, 16'h2211, 2'd3, 1, 0, 16'd1));
    tbl.push_back(row(0, 8'h44, 0, 1,  1, 1, 16'h2211, 2'd3, 1, 0, 16'd1));
    tbl.push_back(row(1, 8'h00, 0, 1,  0, 1, 16'h4433, 2'd3, 0, 0, 16'd2));
    tbl.push_back(row(0, 8'h55, 0, 1,  1, 0, 16'h0000, 2'd0, 0, 0, 16'd3));
    tbl.push_back(row(1, 8'h00, 1, 1,  0, 0, 16'h0000, 2'd0, 1, 0, 16'd3));
    tbl.push_back(row(1, 8'h00, 0, 1,  0, 0, 16'h0000, 2'd0, 1, 1, 16'd3));
    tbl.push_back(row(1, 8'h00, 0, 1,  0, 1, 16'h0055, 2'd1, 0, 0, 16'd3));
    tbl.push_back(row(0, 8'hAA, 0, 0,  1, 0, 16'h0000, 2'd0, 0, 0, 16'd4));
    tbl.push_back(row(0, 8'hBB, 0, 0,  1, 0, 16'h0000, 2'd0, 1, 0, 16'd4));
    tbl.push_back(row(1, 8'h00, 1, 0,  0, 1, 16'hBBAA, 2'd3, 0, 0, 16'd4));
    tbl.push_back(row(0, 8'hCC, 0, 0,  0, 1, 16'hBBAA, 2'd3, 0, 1, 16'd4));
    tbl.push_back(row(0, 8'hCC, 0, 0,  1, 1, 16'hBBAA, 2'd3, 0, 0, 16'd4));
    tbl.push_back(row(0, 8'hDD, 0, 1,  1, 1, 16'hBBAA, 2'd3, 1, 0, 16'd4));
    tbl.push_back(row(1, 8'h00, 0, 1,  0, 1, 16'hDDCC, 2'd3, 0, 0, 16'd5));
    tbl.push_back(row(1, 8'h00, 0, 0,  0, 0, 16'h0000, 2'd0, 0, 0, 16'd6));
    tbl.push_back(row(0, 8'h01, 0, 0,  1, 0, 16'h0000, 2'd0, 0, 0, 16'd6));
    tbl.push_back(row(0, 8'h02, 0, 0,  1, 0, 16'h0000, 2'd0, 1, 0, 16'd6));
    tbl.push_back(row(0, 8'h03, 0, 0,  1, 1, 16'h0201, 2'd3, 0, 0, 16'd6));
    tbl.push_back(row(1, 8'h00, 1, 0,  0, 1, 16'h0201, 2'd3, 1, 0, 16'd6));
    tbl.push_back(row(1, 8'h00, 0, 0,  0, 1, 16'h0201, 2'd3, 1, 1, 16'd6));
    tbl.push_back(row(1, 8'h00, 0, 0,  0, 1, 16'h0201, 2'd3, 1, 1, 16'd6));
    tbl.push_back(row(0, 8'h04, 0, 1,  0, 1, 16'h0201, 2'd3, 1, 1, 16'd6));
    tbl.push_back(row(0, 8'h04, 0, 1,  1, 1, 16'h0003, 2'd1, 0, 0, 16'd7));
    tbl.push_back(row(1, 8'h00, 0, 1,  0, 0, 16'h0000, 2'd0, 1, 0, 16'd8));
    foreach (tbl[i]) apply_row(tbl[i], $sformatf("tbl%0d", i));

    // Reset with idx=1 and a beat pending.
    apply_row(row(0, 8'h05, 0, 0,  1, 0, 16'h0000, 2'd0, 1, 0, 16'd8), "rst_a");
    apply_row(row(0, 8'h06, 0, 0,  1, 1, 16'h0504, 2'd3, 0, 0, 16'd8), "rst_b");
    drive(1'b0, 8'h07, 1'b0, 1'b0);
    #2 rrst = 1'b1;
    #1;
    check_reset_state("rst_async");
    @(posedge rclk);
    #1;
    check_reset_state("rst_held");
    @(negedge rclk);
    rrst = 1'b0;
    apply_row(row(0, 8'h66, 0, 1,  1, 0, 16'h0000, 2'd0, 0, 0, 16'd0), "rst_c");
    apply_row(row(0, 8'h77, 0, 1,  1, 0, 16'h0000, 2'd0, 1, 0, 16'd0), "rst_d");
    apply_row(row(1, 8'h00, 0, 1,  0, 1, 16'h7766, 2'd3, 0, 0, 16'd0), "rst_e");
    apply_row(row(1, 8'h00, 0, 0,  0, 0, 16'h0000, 2'd0, 0, 0, 16'd1), "rst_f");

    // Counter wrap: preload the count near the top, then accept two beats.
    force dut.beat_cnt_q = 16'hFFFE;
    #1;
    release dut.beat_cnt_q;
    apply_row(row(0, 8'h12, 0, 1,  1, 0, 16'h0000, 2'd0, 0, 0, 16'hFFFE), "wrap_a");
    apply_row(row(0, 8'h34, 0, 1,  1, 0, 16'h0000, 2'd0, 1, 0, 16'hFFFE), "wrap_b");
    apply_row(row(0, 8'h56, 0, 1,  1, 1, 16'h3412, 2'd3, 0, 0, 16'hFFFE), "wrap_c");
    apply_row(row(0, 8'h78, 0, 1,  1, 0, 16'h0000, 2'd0, 1, 0, 16'hFFFF), "wrap_d");
    apply_row(row(1, 8'h00, 0, 1,  0, 1, 16'h7856, 2'd3, 0, 0, 16'hFFFF), "wrap_e");
    apply_row(row(1, 8'h00, 0, 0,  0, 0, 16'h0000, 2'd0, 0, 0, 16'h0000), "wrap_f");

    // Randomized traffic against the queue model.
    rrst = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge rclk);
    rrst = 1'b0;
    exp_q.delete(); stg_q.delete(); fifo_q.delete();
    m_fp = 1'b0; m_cnt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        re, fl, rdy, e_rinc, free, acc;
      logic [7:0]  rd;
      logic [15:0] bd;
      logic [1:0]  bk;
      if (cyc == 1500) begin
        // Mid-run reset: staged words and the pending beat are discarded.
        rrst = 1'b1;
        drive(1'b1, 8'h00, 1'b0, 1'b0);
        @(negedge rclk);
        rrst = 1'b0;
        exp_q.delete(); stg_q.delete();
        m_fp = 1'b0; m_cnt = '0;
      end
      if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8)
        fifo_q.push_back(8'($urandom_range(0, 255)));
      re  = (fifo_q.size() == 0);
      rd  = re ? 8'($urandom_range(0, 255)) : fifo_q[0];
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive(re, rd, fl, rdy);
      #1;
      free   = (exp_q.size() == 0) || rdy;
      e_rinc = !re && !fl && !m_fp && ((stg_q.size() != RATIO - 1) || free);
      acc    = (exp_q.size() != 0) && rdy;
      check("rnd.rinc",     32'(bus.rinc),     32'(e_rinc));
      check("rnd.m_valid",  32'(bus.m_valid),  32'(exp_q.size() != 0));
      check("rnd.idx",      32'(dbg_idx),      32'(stg_q.size()));
      check("rnd.flush_pend", 32'(dbg_fp),     32'(m_fp));
      check("rnd.beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
      if (acc) begin
        logic [17:0] b;
        b = exp_q.pop_front();
        check("rnd.beat_data", 32'(bus.m_data), 32'(b[15:0]));
        check("rnd.beat_keep", 32'(bus.m_keep), 32'(b[17:16]));
        m_cnt = m_cnt + 16'd1;
      end
      // Model update for the coming edge.
      if (e_rinc) begin
        stg_q.push_back(rd);
        if (stg_q.size() == RATIO) begin
          bd = '0; bk = '0;
          foreach (stg_q[k]) begin
            bd = bd | (16'(stg_q[k]) << (8 * k));
            bk[k] = 1'b1;
          end
          exp_q.push_back({bk, bd});
          stg_q.delete();
        end
      end else if (m_fp) begin
        if (stg_q.size() == 0) begin
          m_fp = 1'b0;
        end else if (free) begin
          bd = '0; bk = '0;
          foreach (stg_q[k]) begin
            bd = bd | (16'(stg_q[k]) << (8 * k));
            bk[k] = 1'b1;
          end
          exp_q.push_back({bk, bd});
          stg_q.delete();
          m_fp = 1'b0;
        end
      end
      if (fl) m_fp = 1'b1;
      @(posedge rclk);
      @(negedge rclk);
      if (e_rinc) void'(fifo_q.pop_front());
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Purpose: read-clock-domain stage directly downstream of the async FIFO. Pops FIFO words and packs RATIO words into one wide beat on a valid/ready master stream.

Interface
REQ-001 Parameter DSIZE, default 8, width of one FIFO word.
REQ-002 Parameter RATIO, default 2, number of FIFO words per output beat (>=2); lane index width = clog2(RATIO).
REQ-003 rclk  input  1  single clock for the block (FIFO read clock).
REQ-004 rrst  input  1  reset, asynchronous, active-high.
REQ-005 rdata  input  DSIZE  FIFO head word, valid combinationally while rempty=0.
REQ-006 rempty  input  1  FIFO empty flag (already synchronised to rclk).
REQ-007 rinc  output  1  FIFO pop strobe; head word consumed on the rclk edge where rinc=1.
REQ-008 flush  input  1  request to emit a partially filled beat.
REQ-009 m_data  output  DSIZE*RATIO  packed beat; lane 0 = bits [DSIZE-1:0] = oldest word.
REQ-010 m_keep  output  RATIO  per-lane valid mask for m_data.
REQ-011 m_valid  output  1  beat available.
REQ-012 m_ready  input  1  downstream accepts the beat.
REQ-013 beat_cnt  output  16  count of accepted beats.

Function
REQ-014 State: lane index idx, RATIO-1 staging lanes, output register (m_data/m_keep/m_valid), sticky flush_pend, beat_cnt.
REQ-015 out_free = !m_valid | m_ready.
REQ-016 rinc = !rrst & !rempty & !flush & !flush_pend & (idx != RATIO-1 | out_free); no combinational path from rdata to any output.
REQ-017 Pop with idx < RATIO-1: rdata stored in lane idx, idx increments.
REQ-018 Pop with idx = RATIO-1: m_data <= {rdata, staged lanes}, m_keep <= all ones, m_valid <= 1, idx <= 0 (beat visible the cycle after the completing pop).
REQ-019 m_valid, once set, SHALL hold with m_data/m_keep stable until m_valid & m_ready.
REQ-020 m_valid & m_ready with no new beat loaded: m_valid <= 0 next cycle; a new beat SHALL be loadable in the same cycle as acceptance (back-to-back, one beat per cycle sustained when RATIO words are available).
REQ-021 flush=1 sets flush_pend; while flush or flush_pend is set, no pops.
REQ-022 Flush service, idx = 0: flush_pend cleared, no beat generated.
REQ-023 Flush service, idx > 0 and out_free: emit partial beat; filled lanes carry data, unfilled lanes zero, m_keep bit i = 1 for i < idx; idx <= 0; flush_pend cleared.
REQ-024 Flush service, idx > 0 and !out_free: wait with flush_pend held until out_free.
REQ-025 beat_cnt increments by 1 on each m_valid & m_ready, wraps 0xFFFF -> 0x0000.
REQ-026 rempty=1: no pop, idx and staged lanes unchanged indefinitely.

Reset
REQ-027 rrst=1 asynchronously forces idx=0, staged lanes=0, m_data=0, m_keep=0, m_valid=0, flush_pend=0, beat_cnt=0; rinc=0 while rrst=1.
REQ-028 Reset mid-beat SHALL discard staged words and any pending beat; first pop after release fills lane 0.
REQ-029 Release of rrst is synchronous to rclk by the upstream reset synchroniser; first pop no earlier than the first rclk edge after release.

Verification (DSIZE=8, RATIO=2)
REQ-030 FIFO holds 0x11,0x22, m_ready=1 -> rinc high two consecutive cycles; next cycle m_valid=1, m_data=0x2211, m_keep=2'b11; beat_cnt=1 after acceptance.
REQ-031 Words 0x11..0x44, m_ready=0 -> beat 0x2211 held; 0x33 popped to lane 0; rinc=0 with idx=1; after m_ready=1, 0x44 popped and beat 0x4433 follows back-to-back.
REQ-032 Single word 0x55 then rempty=1, one-cycle flush pulse -> next beat m_data=0x0055, m_keep=2'b01, idx=0.
REQ-033 flush with idx=0 and m_valid=1/m_ready=0 -> no extra beat; flush_pend clears one cycle later; pops resume.
REQ-034 rrst asserted with idx=1 and m_valid=1 -> same-cycle m_valid=0, m_data=0, beat_cnt=0, rinc=0; after release, 0x66,0x77 yield beat 0x7766.
REQ-035 65536 accepted beats -> beat_cnt returns to 0x0000.
